// File: rtl/accel_fifo_pkg.sv
// Shared definitions for the accelerator FIFO port.
// Optional feature macro: ACCEL_FIFO_ALMOST_FLAGS_EN enables the
// to_almost_full / from_almost_empty threshold flags; when undefined
// both flags are held at 0.
package accel_fifo_pkg;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned DEPTH_DEF     = 16;
  localparam int unsigned ALMOST_TH_DEF = 2;
  localparam int unsigned PTR_W         = $clog2(DEPTH_DEF);

`ifdef ACCEL_FIFO_ALMOST_FLAGS_EN
  localparam bit ALMOST_FLAGS_EN = 1'b1;
`else
  localparam bit ALMOST_FLAGS_EN = 1'b0;
`endif

  // Per-FIFO status FSM encoding
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter and EMPTY/PARTIAL/FULL status FSM.
// Status flags come straight from the registered FSM state, so they track
// the post-edge occupancy. Pushes while full and pops while empty are
// dropped and reported through the *_drop strobes.
module sync_fifo
  import accel_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_push,
  input  logic [DATA_W-1:0]       i_wr_data,
  input  logic                    i_pop,
  output logic [DATA_W-1:0]       o_head,
  output logic                    o_empty,
  output logic                    o_full,
  output logic                    o_push_fire,
  output logic                    o_pop_fire,
  output logic                    o_push_drop,
  output logic                    o_pop_drop,
  output logic [$clog2(DEPTH):0]  o_count_next
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [AW:0]       w_count_next;
  fifo_state_t       r_state;
  fifo_state_t       w_state_next;
  logic              w_push_fire;
  logic              w_pop_fire;

  // A full FIFO drops the push even if a pop frees a slot in the same cycle
  assign w_push_fire = i_push && (r_state != ST_FULL);
  assign w_pop_fire  = i_pop  && (r_state != ST_EMPTY);

  assign o_push_fire  = w_push_fire;
  assign o_pop_fire   = w_pop_fire;
  assign o_push_drop  = i_push && (r_state == ST_FULL);
  assign o_pop_drop   = i_pop  && (r_state == ST_EMPTY);
  assign o_head       = r_mem[r_rd_ptr];
  assign o_count_next = w_count_next;

  // Storage array write port (no reset: contents are qualified by the count)
  always_ff @(posedge clk) begin
    if (w_push_fire) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two) and the count follows the net transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_fire) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_fire) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
    end
  end

  // Next occupancy from the accepted push/pop pair
  always_comb begin
    w_count_next = r_count;
    unique case ({w_push_fire, w_pop_fire})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Status FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Status FSM next state and flag decode; only a net push or pop moves it
  always_comb begin
    w_state_next = r_state;
    o_empty      = 1'b0;
    o_full       = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        o_empty = 1'b1;
        if (w_push_fire) begin
          w_state_next = ST_PARTIAL;
        end
      end
      ST_PARTIAL: begin
        if (w_push_fire != w_pop_fire) begin
          if (w_count_next == '0) begin
            w_state_next = ST_EMPTY;
          end else if (w_count_next == FULL_CNT) begin
            w_state_next = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        o_full = 1'b1;
        if (w_pop_fire) begin
          w_state_next = ST_PARTIAL;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase
  end

endmodule

// File: rtl/accel_fifo_port.sv
// Router <-> accelerator FIFO port: a to-FIFO (router pushes, accelerator
// pops) and a from-FIFO (accelerator pushes, router pops), registered read
// data on both sides, sticky overflow/underflow flags and optional almost
// flags gated by ACCEL_FIFO_ALMOST_FLAGS_EN (tied to 0 when undefined).
module accel_fifo_port
  import accel_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned ALMOST_TH = ALMOST_TH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              data_to_acc,
  input  logic [DATA_W-1:0] router_data_in,
  input  logic              data_from_acc,
  output logic [DATA_W-1:0] router_data_out,
  output logic              to_empty,
  output logic              to_full,
  output logic              from_empty,
  output logic              from_full,
  input  logic              acc_rd_en,
  output logic [DATA_W-1:0] acc_rd_data,
  output logic              acc_rd_valid,
  input  logic              acc_wr_en,
  input  logic [DATA_W-1:0] acc_wr_data,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic              to_almost_full,
  output logic              from_almost_empty
);

  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam int unsigned AF_INT = DEPTH - ALMOST_TH;
  localparam logic [CW-1:0] AF_TH = AF_INT[CW-1:0];
  localparam logic [CW-1:0] AE_TH = ALMOST_TH[CW-1:0];

  logic [DATA_W-1:0] w_to_head;
  logic [DATA_W-1:0] w_from_head;
  logic              w_to_push_fire;
  logic              w_to_pop_fire;
  logic              w_to_push_drop;
  logic              w_to_pop_drop;
  logic              w_from_push_fire;
  logic              w_from_pop_fire;
  logic              w_from_push_drop;
  logic              w_from_pop_drop;
  logic [CW-1:0]     w_to_count_next;
  logic [CW-1:0]     w_from_count_next;

  logic [DATA_W-1:0] r_router_data_out;
  logic [DATA_W-1:0] r_acc_rd_data;
  logic              r_acc_rd_valid;
  logic              r_overflow_err;
  logic              r_underflow_err;
  logic              r_to_almost_full;
  logic              r_from_almost_empty;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_to_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_push       (data_to_acc),
    .i_wr_data    (router_data_in),
    .i_pop        (acc_rd_en),
    .o_head       (w_to_head),
    .o_empty      (to_empty),
    .o_full       (to_full),
    .o_push_fire  (w_to_push_fire),
    .o_pop_fire   (w_to_pop_fire),
    .o_push_drop  (w_to_push_drop),
    .o_pop_drop   (w_to_pop_drop),
    .o_count_next (w_to_count_next)
  );

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_from_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_push       (acc_wr_en),
    .i_wr_data    (acc_wr_data),
    .i_pop        (data_from_acc),
    .o_head       (w_from_head),
    .o_empty      (from_empty),
    .o_full       (from_full),
    .o_push_fire  (w_from_push_fire),
    .o_pop_fire   (w_from_pop_fire),
    .o_push_drop  (w_from_push_drop),
    .o_pop_drop   (w_from_pop_drop),
    .o_count_next (w_from_count_next)
  );

  // Registered read data: load the head on an accepted pop, otherwise hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_router_data_out <= '0;
      r_acc_rd_data     <= '0;
      r_acc_rd_valid    <= 1'b0;
    end else begin
      r_acc_rd_valid <= w_to_pop_fire;
      if (w_to_pop_fire) begin
        r_acc_rd_data <= w_to_head;
      end
      if (w_from_pop_fire) begin
        r_router_data_out <= w_from_head;
      end
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      r_overflow_err  <= r_overflow_err  | w_to_push_drop | w_from_push_drop;
      r_underflow_err <= r_underflow_err | w_to_pop_drop  | w_from_pop_drop;
    end
  end

  // Threshold flags from post-edge occupancy; constant 0 when the feature is off
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_almost_full    <= 1'b0;
      r_from_almost_empty <= 1'b0;
    end else begin
      r_to_almost_full    <= ALMOST_FLAGS_EN && (w_to_count_next >= AF_TH);
      r_from_almost_empty <= ALMOST_FLAGS_EN && (w_from_count_next <= AE_TH);
    end
  end

  assign router_data_out   = r_router_data_out;
  assign acc_rd_data       = r_acc_rd_data;
  assign acc_rd_valid      = r_acc_rd_valid;
  assign overflow_err      = r_overflow_err;
  assign underflow_err     = r_underflow_err;
  assign to_almost_full    = r_to_almost_full;
  assign from_almost_empty = r_from_almost_empty;

  // Push-fire strobes are not needed at this level; the write side is self-contained
  logic w_unused_push_fire;
  assign w_unused_push_fire = w_to_push_fire ^ w_from_push_fire;

endmodule

// File: doc/accel_fifo_port.md
ACCEL_FIFO_PORT -- requirements
Module: accel_fifo_port

Interface
REQ-001 Parameter DATA_W, default 32, data word width.
REQ-002 Parameter DEPTH, default 16, entries per FIFO (power of two, at least 4).
REQ-003 Parameter ALMOST_TH, default 2, almost-flag margin in entries.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 data_to_acc  in  1  router push strobe into to-FIFO (router->accelerator).
REQ-007 router_data_in  in  DATA_W  word pushed when data_to_acc is high.
REQ-008 data_from_acc  in  1  router pop strobe from from-FIFO (accelerator->router).
REQ-009 router_data_out  out  DATA_W  registered word popped for the router.
REQ-010 to_empty, to_full, from_empty, from_full  out  1 each  registered FIFO status to router.
REQ-011 acc_rd_en  in  1  accelerator pop request on to-FIFO.
REQ-012 acc_rd_data  out  DATA_W; acc_rd_valid  out  1  popped word, qualified by valid.
REQ-013 acc_wr_en  in  1; acc_wr_data  in  DATA_W  accelerator push into from-FIFO.
REQ-014 overflow_err, underflow_err  out  1 each  sticky error flags.
REQ-015 to_almost_full, from_almost_empty  out  1 each  threshold flags (REQ-031).

Function
REQ-016 Both FIFOs SHALL be synchronous, first-in first-out, DEPTH entries, occupancy counter of width log2(DEPTH)+1.
REQ-017 Push: data_to_acc and !to_full writes router_data_in; acc_wr_en and !from_full writes acc_wr_data.
REQ-018 Push while full SHALL be dropped, with no state change other than overflow_err set, even if a pop occurs in the same cycle.
REQ-019 Pop: data_from_acc and !from_empty loads head into router_data_out one cycle later; router_data_out holds its value otherwise.
REQ-020 acc_rd_en and !to_empty: acc_rd_data is the head word and acc_rd_valid is 1 one cycle later; otherwise acc_rd_valid is 0 and acc_rd_data holds.
REQ-021 Pop while empty SHALL be dropped and set underflow_err; a simultaneous push still completes, and its word is readable from the next cycle.
REQ-022 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0 with no bubble.
REQ-024 Flags SHALL reflect post-edge occupancy: empty when count==0, full when count==DEPTH, both valid in the same cycle as the count.
REQ-025 Each FIFO SHALL run a three-state status FSM: EMPTY, PARTIAL, FULL; transitions on net push/pop only; EMPTY->FULL directly when DEPTH==1 is excluded.
REQ-026 Error flags SHALL remain set until reset.

Reset
REQ-027 On reset_n low, asynchronously: pointers and counts 0; FSMs to EMPTY; to_empty=1, from_empty=1, to_full=0, from_full=0; router_data_out=0, acc_rd_data=0, acc_rd_valid=0; error and almost flags 0.
REQ-028 Reset mid-operation SHALL discard all stored words; the first push after release SHALL be the first word popped.
REQ-029 Deassertion is synchronized by the integrating level; the block SHALL NOT push or pop in the cycle reset_n rises.

Configuration
REQ-030 Macro ACCEL_FIFO_ALMOST_FLAGS_EN SHALL gate the almost-flag logic.
REQ-031 Defined: to_almost_full=1 when to-FIFO count >= DEPTH-ALMOST_TH; from_almost_empty=1 when from-FIFO count <= ALMOST_TH; both registered.
REQ-032 Undefined: both ports SHALL remain present and be tied to 0.

Structure
REQ-033 Package accel_fifo_pkg SHALL hold the DATA_W and DEPTH defaults, PTR_W=log2(DEPTH), and the FIFO status FSM state encoding (EMPTY, PARTIAL, FULL).
REQ-034 Sub-module sync_fifo SHALL contain one FIFO with flags and FSM, instantiated twice (to-FIFO and from-FIFO); accel_fifo_port adds the output registers and error flags.

Verification
REQ-035 Reset, then 16 router pushes 0x00..0x0F: to_full=1 after the 16th edge; a 17th push of 0xFF is dropped, overflow_err=1, and 16 acc pops return 0x00..0x0F in order.
REQ-036 Empty from-FIFO, data_from_acc=1 with acc_wr_en=1 and data 0xA5A5A5A5: underflow_err=1, from_empty=0 next cycle, and the next pop returns 0xA5A5A5A5.
REQ-037 40 continuous words with simultaneous push and pop at count 8: count stays 8, order is preserved across pointer wrap, and no error flag is set.
REQ-038 reset_n pulsed low at count 5 mid-stream: flags return to reset values immediately, and the post-reset pop returns the first post-reset word.
REQ-039 With ACCEL_FIFO_ALMOST_FLAGS_EN defined: to_almost_full rises at count 14 and from_almost_empty is 1 at count 2; without the macro, both flags stay 0 throughout.
